// File: rtl/vedic_divider.sv
// ----------------------------------------------------------------------------
// vedic_divider
//   Sequential unsigned restoring divider that pairs with the vedic multiplier.
//   It divides a 2*DIV_Size-bit dividend by a DIV_Size-bit divisor and retires
//   one quotient bit per clock behind a START/BUSY/DONE handshake.
//
// Ports
//   CLK        in   1               rising-edge clock
//   RST_n      in   1               asynchronous active-low reset
//   START      in   1               request, sampled only while idle
//   DIVIDEND   in   Div_Input_Size  numerator, captured on accept
//   DIVISOR    in   DIV_Size        denominator, captured on accept
//   BUSY       out  1               high while running and in the done cycle
//   DONE       out  1               one-cycle pulse, results valid from here
//   QUOTIENT   out  Div_Input_Size  registered quotient
//   REMAINDER  out  DIV_Size        registered remainder
//   DIV_ZERO   out  1               last accepted divisor was zero
//
// Build option
//   VEDIC_DIV_ZERO_FAST_EN : when defined, a zero divisor skips the iteration
//   phase and completes one cycle after accept with the same result values
//   the full iteration would produce.
// ----------------------------------------------------------------------------
module vedic_divider #(
    parameter  int DIV_Size       = 4,
    localparam int Div_Input_Size = 2 * DIV_Size,
    localparam int Cnt_Size       = $clog2(2 * DIV_Size + 1)
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      START,
    input  logic [Div_Input_Size-1:0] DIVIDEND,
    input  logic [DIV_Size-1:0]       DIVISOR,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [Div_Input_Size-1:0] QUOTIENT,
    output logic [DIV_Size-1:0]       REMAINDER,
    output logic                      DIV_ZERO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // The dividend register doubles as the quotient register: each iteration
    // shifts one dividend bit out of the top and one quotient bit into the
    // bottom, so after 2*DIV_Size steps it holds the whole quotient.
    logic [Div_Input_Size-1:0] r_dq;
    logic [DIV_Size-1:0]       r_dvs;
    // Only the low DIV_Size bits of the partial remainder ever feed the next
    // step or the output, so the top bit is not stored.
    logic [DIV_Size-1:0]       r_rem;
    logic [Cnt_Size-1:0]       r_cnt;
    logic [Div_Input_Size-1:0] r_quotient;
    logic [DIV_Size-1:0]       r_remainder;
    logic                      r_div_zero;

    logic [DIV_Size:0]         w_t;
    logic                      w_ge;
    logic [DIV_Size-1:0]       w_sub;
    logic [DIV_Size-1:0]       w_rem_next;
    logic [Div_Input_Size-1:0] w_dq_next;
    logic                      w_last;

    // One restoring step: trial value T = {R, next dividend bit}.
    assign w_t        = {r_rem, r_dq[Div_Input_Size-1]};
    assign w_ge       = (w_t >= {1'b0, r_dvs});
    // When T >= B the true difference is below B, so its low bits are exact.
    assign w_sub      = w_t[DIV_Size-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_sub : w_t[DIV_Size-1:0];
    assign w_dq_next  = {r_dq[Div_Input_Size-2:0], w_ge};
    // Counter is about to reach zero: this edge performs the final iteration.
    assign w_last     = (r_cnt == Cnt_Size'(1));

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
`ifdef VEDIC_DIV_ZERO_FAST_EN
                    if (DIVISOR == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RUN;
                    end
`else
                    w_state_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_dq        <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_dq       <= DIVIDEND;
                        r_dvs      <= DIVISOR;
                        r_rem      <= '0;
                        r_cnt      <= Cnt_Size'(2 * DIV_Size);
                        r_div_zero <= (DIVISOR == '0);
`ifdef VEDIC_DIV_ZERO_FAST_EN
                        // Same values the iterative path yields for B = 0.
                        if (DIVISOR == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= DIVIDEND[DIV_Size-1:0];
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_dq  <= w_dq_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - Cnt_Size'(1);
                    if (w_last) begin
                        r_quotient  <= w_dq_next;
                        r_remainder <= w_rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = (r_state == S_DONE);
    assign QUOTIENT  = r_quotient;
    assign REMAINDER = r_remainder;
    assign DIV_ZERO  = r_div_zero;

endmodule
